// File: rtl/hazard_stall_unit_if.sv
// Bundle between the ID-stage decode/pipeline registers and the hazard stall unit.
// The pipeline side (master) presents register fields; the unit (slave) returns bubble controls.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             BranchTaken;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_WriteReg;
    logic             MEM_MemRead;
    logic [4:0]       MEM_WriteReg;
    logic             ExtStall;
    logic             noOp;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, BranchTaken,
        output EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg, ExtStall,
        input  noOp, PCWrite, IFIDWrite, IFIDFlush, StallCycles
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, BranchTaken,
        input  EX_MemRead, EX_RegWrite, EX_WriteReg, MEM_MemRead, MEM_WriteReg, ExtStall,
        output noOp, PCWrite, IFIDWrite, IFIDFlush, StallCycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: raises decode bubbles, holds PC and IF/ID, flushes IF/ID on
// taken branches, and counts bubble cycles in a saturating performance counter.
module hazard_stall_unit #(
    parameter int CNT_W         = 16,
    parameter int BR_LOAD_STALL = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    hazard_stall_unit_if.slave    hs
);
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [2:0] REM_LOAD = 3'(BR_LOAD_STALL - 1);

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q;
    logic             bubble_s;
    logic             no_op_s;
    logic             ex_hit_s, mem_hit_s;
    logic             hz_a_s, hz_b_s, hz_c_s, hz_d_s, hazard_s;

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    // An EX match only counts when the EX instruction actually produces a register value.
    assign ex_hit_s  = (hs.EX_RegWrite | hs.EX_MemRead) &
                       (reg_match(hs.ID_Rs, hs.EX_WriteReg) |
                        (hs.ID_UsesRt & reg_match(hs.ID_Rt, hs.EX_WriteReg)));
    assign mem_hit_s = hs.MEM_MemRead &
                       (reg_match(hs.ID_Rs, hs.MEM_WriteReg) |
                        (hs.ID_UsesRt & reg_match(hs.ID_Rt, hs.MEM_WriteReg)));

    assign hz_a_s   = hs.EX_MemRead & ~hs.ID_Branch & ex_hit_s;
    assign hz_b_s   = hs.ID_Branch & hs.EX_RegWrite & ~hs.EX_MemRead & ex_hit_s;
    assign hz_c_s   = hs.ID_Branch & hs.EX_MemRead & ex_hit_s;
    assign hz_d_s   = hs.ID_Branch & mem_hit_s & ~ex_hit_s;
    assign hazard_s = hz_a_s | hz_b_s | hz_c_s | hz_d_s;

    // Next-state and bubble decision; ExtStall freezes the FSM ahead of everything else.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        bubble_s = 1'b0;
        if (hs.ExtStall) begin
            bubble_s = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_s) begin
                        bubble_s = 1'b1;
                        if (hz_c_s) begin
                            state_d = STALL;
                            rem_d   = REM_LOAD;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        bubble_s = 1'b0;
                    end
                end
                STALL: begin
                    bubble_s = 1'b1;
                    if (rem_q <= 3'd1) begin
                        state_d = RUN;
                        rem_d   = 3'd0;
                    end else begin
                        rem_d = rem_q - 3'd1;
                    end
                end
                default: begin
                    state_d  = RUN;
                    rem_d    = 3'd0;
                    bubble_s = 1'b1;
                end
            endcase
        end
    end

    // Reset forces a bubble combinationally so nothing advances while Rst_n is low.
    assign no_op_s        = ~Rst_n | bubble_s;
    assign hs.noOp        = no_op_s;
    assign hs.PCWrite     = ~no_op_s;
    assign hs.IFIDWrite   = ~no_op_s;
    assign hs.IFIDFlush   = ~no_op_s & hs.BranchTaken;
    assign hs.StallCycles = cnt_q;

    // FSM state and remaining-stall register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Saturating bubble-cycle counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (no_op_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized bench for hazard_stall_unit, compared against a cycle-count model.
module tb_hazard_stall_unit;
    localparam int BRS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(16)) hif ();
    hazard_stall_unit_if #(.CNT_W(4))  hif4 ();

    hazard_stall_unit #(.CNT_W(16), .BR_LOAD_STALL(BRS)) dut (.Clk(clk), .Rst_n(rst_n), .hs(hif.slave));
    hazard_stall_unit #(.CNT_W(4),  .BR_LOAD_STALL(BRS)) dut4 (.Clk(clk), .Rst_n(rst_n), .hs(hif4.slave));

    int n_cmp = 0;
    int n_fail = 0;

    logic [4:0] rs, rt, exwr, memwr;
    logic       usesrt, br, bt, exmr, exrw, memmr, ext, ext4;

    int m_pend = 0;
    int m_cnt  = 0;
    int m_cnt4 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] r_s, input logic [4:0] r_t, input logic u_rt,
                          input logic b, input logic t, input logic emr, input logic erw,
                          input logic [4:0] ewr, input logic mmr, input logic [4:0] mwr,
                          input logic x);
        rs = r_s; rt = r_t; usesrt = u_rt; br = b; bt = t;
        exmr = emr; exrw = erw; exwr = ewr; memmr = mmr; memwr = mwr; ext = x;
    endtask

    task automatic drive();
        hif.ID_Rs = rs; hif.ID_Rt = rt; hif.ID_UsesRt = usesrt; hif.ID_Branch = br;
        hif.BranchTaken = bt; hif.EX_MemRead = exmr; hif.EX_RegWrite = exrw;
        hif.EX_WriteReg = exwr; hif.MEM_MemRead = memmr; hif.MEM_WriteReg = memwr;
        hif.ExtStall = ext;
        hif4.ID_Rs = 5'd0; hif4.ID_Rt = 5'd0; hif4.ID_UsesRt = 1'b0; hif4.ID_Branch = 1'b0;
        hif4.BranchTaken = 1'b0; hif4.EX_MemRead = 1'b0; hif4.EX_RegWrite = 1'b0;
        hif4.EX_WriteReg = 5'd0; hif4.MEM_MemRead = 1'b0; hif4.MEM_WriteReg = 5'd0;
        hif4.ExtStall = ext4;
    endtask

    // Bubble count demanded by the current ID/EX/MEM contents, from the hazard rules.
    function automatic int model_n();
        bit exh, memh;
        exh  = (exrw || exmr) && ((exwr != 0 && rs == exwr) || (usesrt && exwr != 0 && rt == exwr));
        memh = memmr && ((memwr != 0 && rs == memwr) || (usesrt && memwr != 0 && rt == memwr));
        if (!br && exmr && exh)               return 1;
        if (br && exmr && exh)                return BRS;
        if (br && exrw && exh)                return 1;
        if (br && memh && !exh)               return 1;
        return 0;
    endfunction

    // One clock: drive, compare at negedge, advance the model at the posedge.
    task automatic step();
        int  n, pend_next;
        bit  bub;
        drive();
        @(negedge clk);
        pend_next = m_pend;
        if (ext) bub = 1'b1;
        else if (m_pend > 0) begin bub = 1'b1; pend_next = m_pend - 1; end
        else begin
            n = model_n();
            bub = (n > 0);
            if (n > 0) pend_next = n - 1;
        end
        chk("noOp",        32'(hif.noOp),        32'(bub));
        chk("PCWrite",     32'(hif.PCWrite),     32'(!bub));
        chk("IFIDWrite",   32'(hif.IFIDWrite),   32'(!bub));
        chk("IFIDFlush",   32'(hif.IFIDFlush),   32'(!bub && bt));
        chk("StallCycles", 32'(hif.StallCycles), 32'(m_cnt));
        chk("StallCycles4", 32'(hif4.StallCycles), 32'(m_cnt4));
        @(posedge clk);
        m_pend = pend_next;
        if (bub && m_cnt < 65535) m_cnt++;
        if (ext4 && m_cnt4 < 15) m_cnt4++;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        ext4 = 1'b0;
        drive();
        m_pend = 0; m_cnt = 0; m_cnt4 = 0;
        @(negedge clk);
        chk("rst_noOp",      32'(hif.noOp),        32'd1);
        chk("rst_PCWrite",   32'(hif.PCWrite),     32'd0);
        chk("rst_IFIDWrite", 32'(hif.IFIDWrite),   32'd0);
        chk("rst_IFIDFlush", 32'(hif.IFIDFlush),   32'd0);
        chk("rst_count",     32'(hif.StallCycles), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        ext4 = 1'b0;
        apply_reset();

        // Load-use on rs
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        chk("t1_count", 32'(hif.StallCycles), 32'd1);

        // Branch on load: second bubble holds even though EX changes
        apply_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        chk("t2_count", 32'(hif.StallCycles), 32'd2);

        // Register 0 and rt gating
        apply_reset();
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        chk("t3_count", 32'(hif.StallCycles), 32'd1);

        // Flush without hazard, then taken branch during a class B hazard
        apply_reset();
        set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0); step();
        // class D: load in MEM, nothing in EX
        set_in(5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0); step();
        chk("t4_count", 32'(hif.StallCycles), 32'd2);

        // ExtStall three cycles inside a class C stall
        apply_reset();
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1); step();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        chk("t5_count", 32'(hif.StallCycles), 32'd5);

        // Async reset in the middle of a class C stall
        apply_reset();
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0); step();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); drive();
        rst_n = 1'b0;
        #1;
        chk("t6_noOp",    32'(hif.noOp),    32'd1);
        chk("t6_PCWrite", 32'(hif.PCWrite), 32'd0);
        m_pend = 0; m_cnt = 0; m_cnt4 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); step();
        chk("t6_count", 32'(hif.StallCycles), 32'd0);

        // Saturation of the 4-bit counter
        apply_reset();
        ext4 = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("t6_sat", 32'(hif4.StallCycles), 32'd15);
        chk("t6_sat_noOp", 32'(hif4.noOp), 32'd1);
        ext4 = 1'b0;

        // Randomized traffic over a small register window to provoke frequent matches
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the ID-stage bubble interface: detects pipeline data hazards and drives the noOp flag that zeroes decode control, plus the PC and IF/ID hold and flush controls.
- Sits in the ID stage, between the register-number fields of the instruction in ID and the EX/MEM pipeline registers.
- A small FSM latches the stall length at detection, so multi-cycle stalls are deterministic.
- A saturating counter records bubble cycles for performance measurement.

Parameters:
- CNT_W, 16, width of the StallCycles performance counter.
- BR_LOAD_STALL, 2, total bubble cycles for a branch in ID that consumes a load result still in EX; legal range 2..7.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- ID_UsesRt  input  1  instruction in ID reads rt as a source.
- ID_Branch  input  1  instruction in ID is a branch compared in ID.
- BranchTaken  input  1  ID branch/jump redirect is valid this cycle.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_RegWrite  input  1  instruction in EX writes a register.
- EX_WriteReg  input  5  destination register of the instruction in EX.
- MEM_MemRead  input  1  instruction in MEM is a load.
- MEM_WriteReg  input  5  destination register of the instruction in MEM.
- ExtStall  input  1  external hold request, e.g. multiply/divide busy.
- noOp  output  1  bubble request to the decode control mux.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register write enable.
- IFIDFlush  output  1  clear IF/ID register to a NOP.
- StallCycles  output  CNT_W  saturating count of cycles with noOp=1.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous and active-low.
- Reset state: state=RUN, remaining-stall counter rem=0, StallCycles=0.
- Outputs while Rst_n=0: noOp=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
- Register match rule: a source register matches a destination only if the destination is nonzero. Register 0 never causes a hazard. Rt participates only when ID_UsesRt=1.
- Hazard classes, evaluated only in RUN (N = total bubble cycles):
  - A: EX_MemRead, ID_Branch=0, EX_WriteReg matches: N=1.
  - B: ID_Branch, EX_RegWrite, EX_MemRead=0, EX_WriteReg matches: N=1.
  - C: ID_Branch, EX_MemRead, EX_WriteReg matches: N=BR_LOAD_STALL.
  - D: ID_Branch, MEM_MemRead, MEM_WriteReg matches, and no EX match: N=1.
- Bubble outputs: noOp=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0. These are driven combinationally (Mealy) in the same cycle a hazard is detected in RUN.
- On detection with N>1: load rem=N-1 and go to STALL at the next edge. With N=1, stay in RUN.
- STALL state:
  - Bubble outputs are driven unconditionally.
  - No hazard re-evaluation and no flush.
  - rem decrements each cycle; when rem=1, go to RUN at the edge.
  - On return to RUN, hazards are re-evaluated normally.
- ExtStall=1, in RUN or STALL: bubble outputs are driven and the FSM freezes (rem not decremented, state held). ExtStall has priority over everything except reset.
- Flush rule: in RUN with no hazard and no ExtStall, BranchTaken=1 gives IFIDFlush=1, noOp=0, PCWrite=1, IFIDWrite=1.
- Precedence: a hazard suppresses IFIDFlush. BranchTaken is ignored during any bubble cycle because the branch is not yet resolved.
- Idle outputs: with no hazard and no ExtStall, noOp=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- StallCycles: increments at each edge where noOp=1 and Rst_n=1. Saturates at all-ones with no wrap.
- Reset mid-stall: returns immediately to RUN with rem=0. The pending stall is discarded.

Test Plan:
1. Load-use: EX lw $8 (EX_MemRead=1, EX_WriteReg=8), ID add with rs=8, ID_Branch=0 -> noOp=1, PCWrite=0 for exactly 1 cycle. Next cycle, with EX cleared, outputs are idle. StallCycles=1.
2. Branch on load: EX load to $5, ID beq rs=5, BR_LOAD_STALL=2 -> noOp=1 for 2 consecutive cycles even if EX inputs change after cycle 1. State returns to RUN. StallCycles=2.
3. Register 0 and rt gating:
   - EX load to $0, ID rs=0 -> no stall.
   - EX load to $9, ID rt=9 with ID_UsesRt=0 -> no stall.
   - Same with ID_UsesRt=1 -> 1 bubble.
4. Flush vs hazard:
   - BranchTaken=1 with no hazard -> IFIDFlush=1, noOp=0 for 1 cycle.
   - BranchTaken=1 during class B hazard -> IFIDFlush=0, noOp=1.
5. ExtStall mid-stall: assert ExtStall for 3 cycles during cycle 1 of a class C stall -> total bubbles = 3+2 = 5. StallCycles increments by 5.
6. Async reset mid-stall, plus saturation:
   - Drop Rst_n during STALL -> noOp=1, PCWrite=0 immediately. After release, RUN with idle outputs, StallCycles=0.
   - With CNT_W=4, hold ExtStall for 20 cycles -> StallCycles=15.
